// File: rtl/mdsa_result_streamer.sv
// mdsa_result_streamer
// Output stage of the MDSA bitonic sorter. It captures the sorted N*N matrix
// in one shot when the sorter strobes sort_done. It then plays the elements
// out, element 0 first, over a valid/ready stream.
// The registered buffer is a right-shifting register. The head element always
// sits in the low DW bits, so m_data needs no wide output multiplexer.

module mdsa_result_streamer #(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sort_done,
  input  logic [N*N*DW-1:0]         data_in,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DW-1:0]             m_data,
  output logic [$clog2(N*N)-1:0]    m_index,
  output logic                      m_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam int NE = N * N;
  localparam int IW = $clog2(NE);
  localparam int BW = NE * DW;

  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q,   buf_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic            ovr_q,   ovr_d;

  logic            xfer;
  logic            at_last;

  // Stream outputs come straight from registers. Only en gates m_valid, and
  // m_ready never reaches m_valid or m_data.
  assign m_valid = en && (state_q == STREAM);
  assign m_data  = buf_q[DW-1:0];
  assign m_index = idx_q;
  assign m_last  = m_valid && (idx_q == LAST_IDX);
  assign busy    = (state_q == STREAM);
  assign overrun = ovr_q;

  assign xfer    = m_valid && m_ready;
  assign at_last = (idx_q == LAST_IDX);

  // Next-state logic: capture, shift and count, back-to-back reload, overrun detection.
  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;

    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (sort_done) begin
            buf_d   = data_in;
            idx_d   = '0;
            state_d = STREAM;
          end
        end

        STREAM: begin
          if (xfer && at_last) begin
            idx_d = '0;
            if (sort_done) begin
              // The sorter handed over the next matrix exactly as this one ends.
              // Reload it with no idle cycle in between.
              buf_d   = data_in;
              state_d = STREAM;
            end else begin
              buf_d   = buf_q >> DW;
              state_d = IDLE;
            end
          end else begin
            if (xfer) begin
              buf_d = buf_q >> DW;
              idx_d = idx_q + IW'(1);
            end
            // A strobe arriving mid-stream cannot be accepted. Drop it, flag it.
            if (sort_done) begin
              ovr_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      // NOTE: the wide buffer is reset on purpose, so an aborted stream leaves no stale data on m_data.
      buf_q   <= '0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_mdsa_result_streamer.sv
// Self-checking bench for mdsa_result_streamer.
// Each accepted capture pushes its 64 expected elements into a scoreboard queue.
// A negedge monitor compares every valid beat against the queue head.
// It pops the head when the beat transfers.

module tb_mdsa_result_streamer;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int NE = N * N;
  localparam int IW = $clog2(NE);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 sort_done;
  logic [NE*DW-1:0]     data_in;
  logic                 m_valid;
  logic                 m_ready;
  logic [DW-1:0]        m_data;
  logic [IW-1:0]        m_index;
  logic                 m_last;
  logic                 busy;
  logic                 overrun;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  mdsa_result_streamer #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sort_done (sort_done),
    .data_in   (data_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a matrix with element k = base + k and strobe sort_done for one edge.
  // When push is set, the capture is expected to be accepted.
  task automatic load(input logic [DW-1:0] base, input bit push);
    for (int k = 0; k < NE; k++) begin
      data_in[k*DW +: DW] = base + DW'(k);
      if (push) sb_q.push_back('{data: base + DW'(k), idx: IW'(k)});
    end
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
  endtask

  // Run until the scoreboard is empty and the block is idle, within a cycle budget.
  task automatic drain(input int budget, input bit rnd_ready);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("drain_done", {63'd0, (sb_q.size() == 0 && !busy)}, 64'd1);
    m_ready = 1'b1;
  endtask

  // Monitor: any valid beat must match the scoreboard head, stalled or not.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 64'(m_index), 64'hFFFF_FFFF);
      end else begin
        check("m_data",  64'(m_data),  64'(sb_q[0].data));
        check("m_index", 64'(m_index), 64'(sb_q[0].idx));
        check("m_last",  64'(m_last),  64'(sb_q[0].idx == IW'(NE - 1)));
        if (m_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    sort_done = 1'b0;
    m_ready   = 1'b0;
    data_in   = '0;

    // Reset, then idle.
    repeat (2) tick();
    check("rst_valid", 64'(m_valid), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid",   64'(m_valid), 64'd0);
      check("idle_data",    64'(m_data),  64'd0);
      check("idle_busy",    64'(busy),    64'd0);
      check("idle_overrun", 64'(overrun), 64'd0);
    end
    check("idle_index", 64'(m_index), 64'd0);
    check("idle_last",  64'(m_last),  64'd0);

    // Full stream with m_ready held high: the first element appears one cycle after capture.
    // The stream runs 64 cycles.
    m_ready = 1'b1;
    load(32'h1000_0000, 1'b1);
    check("cap_valid", 64'(m_valid), 64'd1);
    check("cap_data",  64'(m_data),  64'h1000_0000);
    check("cap_index", 64'(m_index), 64'd0);
    repeat (NE - 1) tick();
    check("full_busy_63", 64'(busy),    64'd1);
    check("full_last_63", 64'(m_last),  64'd1);
    tick();
    check("full_busy_end",  64'(busy),        64'd0);
    check("full_valid_end", 64'(m_valid),     64'd0);
    check("full_sb_empty",  64'(sb_q.size()), 64'd0);

    // Back-pressure: every element must arrive once, in order, and hold while stalled.
    m_ready = 1'b0;
    load(32'h1000_0000, 1'b1);
    drain(2000, 1'b1);
    check("bp_overrun", 64'(overrun), 64'd0);

    // Back-to-back: a new strobe on the index-63 transfer reloads the buffer with no bubble.
    m_ready = 1'b1;
    load(32'h1000_0000, 1'b1);
    repeat (NE - 1) tick();
    check("b2b_at_63", 64'(m_index), 64'd63);
    load(32'hA000_0000, 1'b1);
    check("b2b_valid",   64'(m_valid), 64'd1);
    check("b2b_index",   64'(m_index), 64'd0);
    check("b2b_data",    64'(m_data),  64'hA000_0000);
    check("b2b_overrun", 64'(overrun), 64'd0);
    drain(200, 1'b0);
    check("b2b_overrun_end", 64'(overrun), 64'd0);

    // Overrun: a strobe at index 10 is dropped. The original data keeps flowing.
    load(32'h1000_0000, 1'b1);
    repeat (10) tick();
    check("ovr_at_10", 64'(m_index), 64'd10);
    load(32'hB000_0000, 1'b0);
    check("ovr_set",  64'(overrun), 64'd1);
    check("ovr_data", 64'(m_data),  64'h1000_000B);
    drain(200, 1'b0);
    repeat (3) tick();
    check("ovr_sticky", 64'(overrun), 64'd1);

    // en freeze at index 20, then an abort by reset at index 40.
    load(32'h1000_0000, 1'b1);
    repeat (20) tick();
    check("frz_at_20", 64'(m_index), 64'd20);
    en = 1'b0;
    #1;
    check("frz_valid_now", 64'(m_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_valid", 64'(m_valid), 64'd0);
      check("frz_index", 64'(m_index), 64'd20);
    end
    en = 1'b1;
    #1;
    check("frz_resume_valid", 64'(m_valid), 64'd1);
    check("frz_resume_data",  64'(m_data),  64'h1000_0014);
    repeat (20) tick();
    check("abort_at_40", 64'(m_index), 64'd40);
    rst = 1'b1;
    #1;
    check("abort_valid",   64'(m_valid), 64'd0);
    check("abort_index",   64'(m_index), 64'd0);
    check("abort_data",    64'(m_data),  64'd0);
    check("abort_busy",    64'(busy),    64'd0);
    check("abort_overrun", 64'(overrun), 64'd0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_valid", 64'(m_valid), 64'd0);
    check("post_busy",  64'(busy),    64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
